// File: rtl/exec_fsm_pkg.sv
// Shared definitions for the execute-phase control FSM: opcodes, ALU and
// error encodings, IR field positions and the state type.
package exec_fsm_pkg;

  localparam int MFC_TIMEOUT_DEF = 255;
  localparam int TO_W_DEF        = 8;

  localparam int IR_OP_HI   = 15;
  localparam int IR_OP_LO   = 12;
  localparam int IR_RD_HI   = 11;
  localparam int IR_RD_LO   = 10;
  localparam int IR_RS_HI   = 9;
  localparam int IR_RS_LO   = 8;
  localparam int IR_ADDR_HI = 7;
  localparam int IR_ADDR_LO = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_MOVI  = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'h8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [4:0] {
    S_IDLE, S_DECODE,
    S_LD_A, S_LD_M, S_LD_R, S_LD_W,
    S_ST_A, S_ST_D, S_ST_M,
    S_AL_A, S_AL_B, S_AL_W,
    S_MV, S_JP,
    S_PCINC, S_DONE, S_HALTED
  } state_t;

  function automatic logic [1:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/exec_fsm_mfc_timer.sv
// Memory-wait watchdog: counts cycles without MFC and flags the cycle on which
// the count would reach MFC_TIMEOUT.
module exec_fsm_mfc_timer #(
  parameter int MFC_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TO_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is raised on the last permitted wait cycle, so the wait state is
  // occupied for exactly MFC_TIMEOUT cycles before giving up.
  assign o_expired = i_enable && (r_count == TO_W'(MFC_TIMEOUT - 1));

endmodule

// File: rtl/exec_fsm.sv
// Execute-phase control FSM: latches IR on start, decodes it and sequences the
// datapath strobes as Moore outputs, then pulses done to restart fetch.
module exec_fsm
  import exec_fsm_pkg::*;
#(
  parameter int MFC_TIMEOUT = MFC_TIMEOUT_DEF,
  parameter int TO_W        = TO_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] IR,
  input  logic        MFC,
  output logic        done,
  output logic        halted,
  output logic [1:0]  err,
  output logic        MARin,
  output logic        memEN,
  output logic        RW,
  output logic        MDRreadEN,
  output logic        MDRin,
  output logic        MDRout,
  output logic        regOut,
  output logic        regIn,
  output logic [1:0]  regSel,
  output logic        Yin,
  output logic [1:0]  aluOp,
  output logic        Zin,
  output logic        Zout,
  output logic        IRaddrOut,
  output logic        PCin,
  output logic        PCinc
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [1:0]  r_err;
  logic [3:0]  w_op;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs;
  logic        w_mem_wait;
  logic        w_expired;
  logic        w_accept;
  logic        w_unused_addr;

  assign w_op     = r_ir[IR_OP_HI:IR_OP_LO];
  assign w_rd     = r_ir[IR_RD_HI:IR_RD_LO];
  assign w_rs     = r_ir[IR_RS_HI:IR_RS_LO];
  assign w_accept = (r_state == S_IDLE) && start;
  // The address/immediate field reaches the bus through the datapath, not here.
  assign w_unused_addr = ^r_ir[IR_ADDR_HI:IR_ADDR_LO];

  assign w_mem_wait = (r_state == S_LD_M) || (r_state == S_ST_M);

  exec_fsm_mfc_timer #(
    .MFC_TIMEOUT (MFC_TIMEOUT),
    .TO_W        (TO_W)
  ) u_mfc_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_mem_wait),
    .i_enable  (w_mem_wait && !MFC),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ir  <= IR;
        r_err <= ERR_NONE;
      end else if (r_state == S_DECODE && w_op > OP_HALT) begin
        r_err <= ERR_ILLEGAL;
      end else if (w_expired) begin
        r_err <= ERR_TIMEOUT;
      end
    end
  end

  assign err = r_err;

  // NOTE: every output and w_next gets a default first so no path through the
  // case leaves a value unassigned (which would infer a latch).
  always_comb begin
    w_next    = r_state;
    done      = 1'b0;
    halted    = 1'b0;
    MARin     = 1'b0;
    memEN     = 1'b0;
    RW        = 1'b0;
    MDRreadEN = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    regOut    = 1'b0;
    regIn     = 1'b0;
    regSel    = 2'b00;
    Yin       = 1'b0;
    aluOp     = ALU_ADD;
    Zin       = 1'b0;
    Zout      = 1'b0;
    IRaddrOut = 1'b0;
    PCin      = 1'b0;
    PCinc     = 1'b0;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_DECODE;
      S_DECODE: begin
        unique case (w_op)
          OP_NOP:                 w_next = S_PCINC;
          OP_LOAD:                w_next = S_LD_A;
          OP_STORE:               w_next = S_ST_A;
          OP_ADD, OP_SUB, OP_AND: w_next = S_AL_A;
          OP_MOVI:                w_next = S_MV;
          OP_JMP:                 w_next = S_JP;
          OP_HALT:                w_next = S_HALTED;
          default:                w_next = S_PCINC;
        endcase
      end
      S_LD_A:   begin IRaddrOut = 1'b1; MARin = 1'b1; w_next = S_LD_M; end
      S_LD_M: begin
        memEN = 1'b1;
        RW    = 1'b1;
        if (MFC)            w_next = S_LD_R;
        else if (w_expired) w_next = S_PCINC;
      end
      S_LD_R:   begin memEN = 1'b1; RW = 1'b1; MDRreadEN = 1'b1; w_next = S_LD_W; end
      S_LD_W:   begin MDRout = 1'b1; regIn = 1'b1; regSel = w_rd; w_next = S_PCINC; end
      S_ST_A:   begin IRaddrOut = 1'b1; MARin = 1'b1; w_next = S_ST_D; end
      S_ST_D:   begin regOut = 1'b1; regSel = w_rs; MDRin = 1'b1; w_next = S_ST_M; end
      S_ST_M: begin
        memEN = 1'b1;
        if (MFC || w_expired) w_next = S_PCINC;
      end
      S_AL_A:   begin regOut = 1'b1; regSel = w_rd; Yin = 1'b1; w_next = S_AL_B; end
      S_AL_B: begin
        regOut = 1'b1;
        regSel = w_rs;
        aluOp  = alu_op_of(w_op);
        Zin    = 1'b1;
        w_next = S_AL_W;
      end
      S_AL_W:   begin Zout = 1'b1; regIn = 1'b1; regSel = w_rd; w_next = S_PCINC; end
      S_MV:     begin IRaddrOut = 1'b1; regIn = 1'b1; regSel = w_rd; w_next = S_PCINC; end
      S_JP:     begin IRaddrOut = 1'b1; PCin = 1'b1; w_next = S_DONE; end
      S_PCINC:  begin PCinc = 1'b1; w_next = S_DONE; end
      S_DONE:   begin done = 1'b1; w_next = S_IDLE; end
      S_HALTED: halted = 1'b1;
      default:  w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_fsm.sv
// Self-checking bench for exec_fsm: per-instruction expected control traces
// are queued at issue time and compared cycle by cycle against the outputs.
module tb_exec_fsm;

  logic        clk = 1'b0;
  logic        rst, start, MFC;
  logic [15:0] IR;
  logic        done, halted, MARin, memEN, RW, MDRreadEN, MDRin, MDRout;
  logic        regOut, regIn, Yin, Zin, Zout, IRaddrOut, PCin, PCinc;
  logic [1:0]  err, regSel, aluOp;

  typedef struct packed {
    logic       done;
    logic       halted;
    logic [1:0] err;
    logic       mar_in;
    logic       mem_en;
    logic       rw;
    logic       mdr_read_en;
    logic       mdr_in;
    logic       mdr_out;
    logic       reg_out;
    logic       reg_in;
    logic [1:0] reg_sel;
    logic       y_in;
    logic [1:0] alu_op;
    logic       z_in;
    logic       z_out;
    logic       ir_addr_out;
    logic       pc_in;
    logic       pc_inc;
  } ctl_t;

  ctl_t       w_obs;
  ctl_t       exp_q[$];
  logic [1:0] exp_err;
  int         checks;
  int         failures;

  exec_fsm dut (
    .clk(clk), .rst(rst), .start(start), .IR(IR), .MFC(MFC),
    .done(done), .halted(halted), .err(err), .MARin(MARin), .memEN(memEN),
    .RW(RW), .MDRreadEN(MDRreadEN), .MDRin(MDRin), .MDRout(MDRout),
    .regOut(regOut), .regIn(regIn), .regSel(regSel), .Yin(Yin),
    .aluOp(aluOp), .Zin(Zin), .Zout(Zout), .IRaddrOut(IRaddrOut),
    .PCin(PCin), .PCinc(PCinc)
  );

  always #5 clk = ~clk;

  assign w_obs = {done, halted, err, MARin, memEN, RW, MDRreadEN, MDRin, MDRout,
                  regOut, regIn, regSel, Yin, aluOp, Zin, Zout, IRaddrOut, PCin, PCinc};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory wait: waits cycles with MFC low then one with MFC high; 255 or more
  // means MFC never comes and the watchdog fires after 255 wait cycles.
  task automatic mem_wait(input ctl_t c, input int first_cyc, input int waits,
                          output int mfc_cyc, output logic timed_out);
    int n;
    timed_out = (waits >= 255);
    n         = timed_out ? 255 : waits + 1;
    mfc_cyc   = timed_out ? -1 : first_cyc + waits;
    for (int i = 0; i < n; i++) exp_q.push_back(c);
  endtask

  task automatic build(input logic [15:0] ir, input int waits, output int mfc_cyc);
    logic [3:0] op;
    logic [1:0] rd, rs, e;
    logic       to, tail, pcinc;
    ctl_t       c;
    op = ir[15:12]; rd = ir[11:10]; rs = ir[9:8];
    e = 2'b00; to = 1'b0; tail = 1'b1; pcinc = 1'b1; mfc_cyc = -1;
    exp_q.push_back('0);
    case (op)
      4'h1: begin
        c = '0; c.ir_addr_out = 1; c.mar_in = 1; exp_q.push_back(c);
        c = '0; c.mem_en = 1; c.rw = 1;
        mem_wait(c, 3, waits, mfc_cyc, to);
        if (!to) begin
          c.mdr_read_en = 1; exp_q.push_back(c);
          c = '0; c.mdr_out = 1; c.reg_in = 1; c.reg_sel = rd; exp_q.push_back(c);
        end
      end
      4'h2: begin
        c = '0; c.ir_addr_out = 1; c.mar_in = 1; exp_q.push_back(c);
        c = '0; c.reg_out = 1; c.reg_sel = rs; c.mdr_in = 1; exp_q.push_back(c);
        c = '0; c.mem_en = 1;
        mem_wait(c, 4, waits, mfc_cyc, to);
      end
      4'h3, 4'h4, 4'h5: begin
        c = '0; c.reg_out = 1; c.reg_sel = rd; c.y_in = 1; exp_q.push_back(c);
        c = '0; c.reg_out = 1; c.reg_sel = rs; c.z_in = 1; c.alu_op = 2'(op - 4'd3);
        exp_q.push_back(c);
        c = '0; c.z_out = 1; c.reg_in = 1; c.reg_sel = rd; exp_q.push_back(c);
      end
      4'h6: begin
        c = '0; c.ir_addr_out = 1; c.reg_in = 1; c.reg_sel = rd; exp_q.push_back(c);
      end
      4'h7: begin
        c = '0; c.ir_addr_out = 1; c.pc_in = 1; exp_q.push_back(c);
        pcinc = 1'b0;
      end
      4'h8: begin
        c = '0; c.halted = 1;
        for (int i = 0; i < 100; i++) exp_q.push_back(c);
        tail = 1'b0;
      end
      4'h0: ;
      default: e = 2'b01;
    endcase
    if (to) e = 2'b10;
    if (tail) begin
      c = '0; c.err = e;
      if (pcinc) begin c.pc_inc = 1; exp_q.push_back(c); c.pc_inc = 0; end
      c.done = 1; exp_q.push_back(c); c.done = 0;
      exp_q.push_back(c); exp_q.push_back(c);
    end
    exp_err = e;
  endtask

  // rst_cyc: cycle during which rst is high (-1 none); glitch_cyc: cycle during
  // which a stray start with a HALT opcode is driven (-1 none).
  task automatic run(input string name, input logic [15:0] ir, input int waits,
                     input int rst_cyc, input int glitch_cyc, input int exp_done);
    int   mfc_cyc, cyc, done_cyc;
    ctl_t c;
    c = '0; c.err = exp_err;
    build(ir, waits, mfc_cyc);
    if (rst_cyc > 0) begin
      while (exp_q.size() > rst_cyc) void'(exp_q.pop_back());
      for (int i = 0; i < 3; i++) exp_q.push_back('0);
      exp_err = 2'b00;
    end
    @(posedge clk); #1;
    start = 1'b1; IR = ir; MFC = 1'b0;
    @(negedge clk);
    check({name, " c0"}, 32'(w_obs), 32'(c));
    cyc = 1; done_cyc = -1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = (cyc == glitch_cyc);
      if (cyc == glitch_cyc) IR = 16'h8000;
      MFC = (cyc == mfc_cyc);
      rst = (cyc == rst_cyc);
      @(negedge clk);
      c = exp_q.pop_front();
      check($sformatf("%s c%0d", name, cyc), 32'(w_obs), 32'(c));
      if (w_obs.done && done_cyc < 0) done_cyc = cyc;
      cyc++;
    end
    check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    @(posedge clk); #1;
    start = 1'b0; MFC = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; MFC = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(name, 32'(w_obs), 32'h0);
    #1 rst = 1'b0;
    exp_err = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; exp_err = 2'b00;
    rst = 1'b1; start = 1'b0; MFC = 1'b0; IR = 16'h0000;
    do_reset("reset");
    run("nop",      16'h0000, 0,   -1, -1, 3);
    run("load",     16'h1412, 2,   -1, -1, 9);
    run("add",      16'h3600, 0,   -1, -1, 6);
    run("jmp",      16'h70AB, 0,   -1, -1, 3);
    run("movi",     16'h6C55, 0,   -1, -1, 4);
    run("sub",      16'h4E00, 0,   -1, -1, 6);
    run("and",      16'h5100, 0,   -1, -1, 6);
    run("store",    16'h2B34, 0,   -1, -1, 6);
    run("illegal",  16'hF000, 0,   -1, -1, 3);
    // 3 lead-in cycles, 255 wait cycles in ST_M (4..258), PCINC 259, DONE 260.
    run("st_tmo",   16'h2112, 255, -1, -1, 260);
    run("nop_clr",  16'h0000, 0,   -1, -1, 3);
    run("ld_rst",   16'h1412, 10,  4,  -1, -1);
    run("add_strt", 16'h3600, 0,   -1, 3,  6);
    run("load0",    16'h1412, 0,   -1, -1, 7);
    run("halt",     16'h8000, 0,   -1, -1, -1);
    do_reset("halt_reset");
    run("nop_after",16'h0000, 0,   -1, -1, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
